// File: rtl/chip8_mem_if.sv
// CHIP-8 memory port bundle: CPU read/ack and write-strobe port, loader stream, status.
interface chip8_mem_if;
    logic        cpu_read;
    logic [11:0] cpu_read_idx;
    logic        cpu_read_ack;
    logic [7:0]  cpu_read_byte;
    logic        cpu_write;
    logic [11:0] cpu_write_idx;
    logic [7:0]  cpu_write_byte;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_done;
    logic [11:0] load_count;
    logic        load_overflow;
    logic        cpu_run;

    modport master (
        output cpu_read, cpu_read_idx, cpu_write, cpu_write_idx, cpu_write_byte,
        output load_valid, load_byte, load_done,
        input  cpu_read_ack, cpu_read_byte, load_ready, load_count, load_overflow, cpu_run
    );

    modport slave (
        input  cpu_read, cpu_read_idx, cpu_write, cpu_write_idx, cpu_write_byte,
        input  load_valid, load_byte, load_done,
        output cpu_read_ack, cpu_read_byte, load_ready, load_count, load_overflow, cpu_run
    );
endinterface

// File: rtl/chip8_mem.sv
// CHIP-8 4 KiB byte memory: copies the hex font in after reset (INIT), takes the
// program stream from the loader (LOAD), then serves the CPU (RUN) until reset.
module chip8_mem #(
    parameter logic [11:0] FONT_BASE   = 12'h000,
    parameter logic [11:0] PROG_BASE   = 12'h200,
    parameter bit          LOAD_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    chip8_mem_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Program space from PROG_BASE to the top of memory; 13 bits so PROG_BASE=0 still fits.
    localparam logic [12:0] PROG_SPACE = 13'h1000 - {1'b0, PROG_BASE};

    // Standard CHIP-8 hex glyphs, five rows each, addressed by a linear 0..79 pointer.
    function automatic logic [7:0] font_byte(input logic [6:0] ptr);
        logic [39:0] glyph;
        case (ptr / 7'd5)
            7'd0:    glyph = 40'hF0_90_90_90_F0;
            7'd1:    glyph = 40'h20_60_20_20_70;
            7'd2:    glyph = 40'hF0_10_F0_80_F0;
            7'd3:    glyph = 40'hF0_10_F0_10_F0;
            7'd4:    glyph = 40'h90_90_F0_10_10;
            7'd5:    glyph = 40'hF0_80_F0_10_F0;
            7'd6:    glyph = 40'hF0_80_F0_90_F0;
            7'd7:    glyph = 40'hF0_10_20_40_40;
            7'd8:    glyph = 40'hF0_90_F0_90_F0;
            7'd9:    glyph = 40'hF0_90_F0_10_F0;
            7'd10:   glyph = 40'hF0_90_F0_90_90;
            7'd11:   glyph = 40'hE0_90_E0_90_E0;
            7'd12:   glyph = 40'hF0_80_80_80_F0;
            7'd13:   glyph = 40'hE0_90_90_90_E0;
            7'd14:   glyph = 40'hF0_80_F0_80_F0;
            7'd15:   glyph = 40'hF0_80_F0_80_80;
            default: glyph = 40'h00_00_00_00_00;
        endcase
        case (ptr % 7'd5)
            7'd0:    font_byte = glyph[39:32];
            7'd1:    font_byte = glyph[31:24];
            7'd2:    font_byte = glyph[23:16];
            7'd3:    font_byte = glyph[15:8];
            default: font_byte = glyph[7:0];
        endcase
    endfunction

    logic [7:0]  mem [0:4095];

    state_e      state_q, state_d;
    logic [6:0]  init_ptr_q, init_ptr_d;
    logic [11:0] load_count_q, load_count_d;
    logic        load_overflow_q, load_overflow_d;
    logic        load_ready_q, load_ready_d;
    logic        cpu_run_q, cpu_run_d;
    logic        read_ack_q, read_ack_d;
    logic [7:0]  read_byte_q, read_byte_d;

    logic        prog_full_s;
    logic        wr_req_s;
    logic        wr_en_s;
    logic [11:0] wr_addr_s;
    logic [7:0]  wr_data_s;

    // Next-state, single write-port mux (font / loader / CPU) and registered status outputs.
    always_comb begin
        state_d         = state_q;
        init_ptr_d      = init_ptr_q;
        load_count_d    = load_count_q;
        load_overflow_d = load_overflow_q;
        read_ack_d      = 1'b0;
        read_byte_d     = read_byte_q;
        wr_req_s        = 1'b0;
        wr_addr_s       = 12'h000;
        wr_data_s       = 8'h00;
        prog_full_s     = ({1'b0, load_count_q} >= PROG_SPACE);

        case (state_q)
            ST_INIT: begin
                wr_req_s  = 1'b1;
                wr_addr_s = FONT_BASE + {5'b00000, init_ptr_q};
                wr_data_s = font_byte(init_ptr_q);
                if (init_ptr_q == 7'd79) begin
                    init_ptr_d = 7'd0;
                    state_d    = LOAD_ENABLE ? ST_LOAD : ST_RUN;
                end else begin
                    init_ptr_d = init_ptr_q + 7'd1;
                end
            end
            ST_LOAD: begin
                if (bus.load_valid && !prog_full_s) begin
                    wr_req_s     = 1'b1;
                    wr_addr_s    = PROG_BASE + load_count_q;
                    wr_data_s    = bus.load_byte;
                    load_count_d = load_count_q + 12'd1;
                end else if (bus.load_valid) begin
                    load_overflow_d = 1'b1;
                end else begin
                    load_overflow_d = load_overflow_q;
                end
                // A byte arriving with load_done is still written above before leaving LOAD.
                if (bus.load_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                read_ack_d = bus.cpu_read;
                if (bus.cpu_read) begin
                    // Array read happens before the edge, so a same-address write returns old data.
                    read_byte_d = mem[bus.cpu_read_idx];
                end else begin
                    read_byte_d = read_byte_q;
                end
                wr_req_s  = bus.cpu_write;
                wr_addr_s = bus.cpu_write_idx;
                wr_data_s = bus.cpu_write_byte;
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = 7'd0;
            end
        endcase

        // No array update while reset is held: contents survive a reset untouched.
        wr_en_s      = wr_req_s & ~reset;
        load_ready_d = (state_d == ST_LOAD) && ({1'b0, load_count_d} < PROG_SPACE);
        cpu_run_d    = (state_d == ST_RUN);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_INIT;
            init_ptr_q      <= 7'd0;
            load_count_q    <= 12'd0;
            load_overflow_q <= 1'b0;
            load_ready_q    <= 1'b0;
            cpu_run_q       <= 1'b0;
            read_ack_q      <= 1'b0;
            read_byte_q     <= 8'h00;
        end else begin
            state_q         <= state_d;
            init_ptr_q      <= init_ptr_d;
            load_count_q    <= load_count_d;
            load_overflow_q <= load_overflow_d;
            load_ready_q    <= load_ready_d;
            cpu_run_q       <= cpu_run_d;
            read_ack_q      <= read_ack_d;
            read_byte_q     <= read_byte_d;
        end
    end

    // Byte array write port; never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    assign bus.cpu_read_ack  = read_ack_q;
    assign bus.cpu_read_byte = read_byte_q;
    assign bus.load_ready    = load_ready_q;
    assign bus.load_count    = load_count_q;
    assign bus.load_overflow = load_overflow_q;
    assign bus.cpu_run       = cpu_run_q;

endmodule
